// File: rtl/expr_check_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : expr_check_arbiter
//  Description : Round-robin arbiter sharing one expression validator between
//                two byte-stream requesters. An owner is granted for a whole
//                expression (terminated by TERM); the grammar
//                digit((+|*)digit)* is checked one byte per cycle, and a
//                one-cycle result tagged with the owner id is produced.
//                Optional macro EXPR_EVAL_EN adds a left-to-right evaluator
//                (no precedence) that drives res_value.
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_check_arbiter #(
  parameter logic [7:0] TERM    = 8'h3B,
  parameter int         TIMEOUT = 16,
  parameter int         VW      = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0_valid,
  input  logic [7:0]    req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [7:0]    req1_data,
  output logic          req1_ready,
  output logic          res_valid,
  output logic          res_ok,
  output logic          res_id,
  output logic [VW-1:0] res_value,
  output logic          busy
);

  // Idle counter only needs to hold TIMEOUT-1 before the abort fires.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REPORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CHK_EXP_DIG = 2'd0,
    CHK_AFT_DIG = 2'd1,
    CHK_FAIL    = 2'd2
  } chk_t;

  state_t        state, state_nxt;
  chk_t          chk, chk_nxt;
  logic          owner;
  logic          last_grant;
  logic          ok_r;
  logic [CW-1:0] idle_cnt;

  logic          grant_owner;
  logic          any_valid;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          xfer;
  logic          is_term;
  logic          is_digit;
  logic          is_op;
  logic          timeout_hit;

`ifdef EXPR_EVAL_EN
  logic [VW-1:0] acc;
  logic          mul_op;
  logic          first;
  logic [VW-1:0] dval;
`endif

  // Byte classification of the owner's stream and the arbitration decision.
  always_comb begin
    any_valid   = req0_valid | req1_valid;
    grant_owner = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    sel_valid   = owner ? req1_valid : req0_valid;
    sel_data    = owner ? req1_data  : req0_data;
    is_term     = (sel_data == TERM);
    is_digit    = (sel_data >= 8'h30) && (sel_data <= 8'h39);
    is_op       = (sel_data == 8'h2B) || (sel_data == 8'h2A);
    chk_nxt     = chk;
    unique case (chk)
      CHK_EXP_DIG: chk_nxt = is_digit ? CHK_AFT_DIG : CHK_FAIL;
      CHK_AFT_DIG: chk_nxt = is_op    ? CHK_EXP_DIG : CHK_FAIL;
      default:     chk_nxt = CHK_FAIL;
    endcase
  end

  // Top FSM state register; reset discards any partial expression.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; outputs are zero outside their states.
  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    res_valid   = 1'b0;
    res_ok      = 1'b0;
    res_id      = 1'b0;
    res_value   = '0;
    xfer        = 1'b0;
    timeout_hit = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any_valid) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        req0_ready = ~owner;
        req1_ready = owner;
        xfer       = sel_valid;
        if (xfer) begin
          if (is_term) state_nxt = REPORT;
        end else if ((TIMEOUT != 0) && (idle_cnt == CW'(TIMEOUT - 1))) begin
          timeout_hit = 1'b1;
          state_nxt   = REPORT;
        end
      end
      REPORT: begin
        res_valid = 1'b1;
        res_ok    = ok_r;
        res_id    = owner;
`ifdef EXPR_EVAL_EN
        res_value = ok_r ? acc : '0;
`else
        res_value = '0;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, grammar checker and idle-cycle watchdog.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      chk        <= CHK_EXP_DIG;
      idle_cnt   <= '0;
      ok_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            owner    <= grant_owner;
            chk      <= CHK_EXP_DIG;
            idle_cnt <= '0;
            ok_r     <= 1'b0;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (is_term) ok_r <= (chk == CHK_AFT_DIG);
            else         chk  <= chk_nxt;
          end else if (timeout_hit) begin
            ok_r <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        REPORT: begin
          last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

`ifdef EXPR_EVAL_EN
  // Digit value of the current byte, widened to the accumulator width.
  always_comb begin
    dval = VW'(sel_data[3:0]);
  end

  // Left-to-right accumulator: first digit loads, later digits apply the stored op.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc    <= '0;
      mul_op <= 1'b0;
      first  <= 1'b1;
    end else if (state == IDLE) begin
      if (any_valid) begin
        acc    <= '0;
        mul_op <= 1'b0;
        first  <= 1'b1;
      end
    end else if ((state == ACTIVE) && xfer && !is_term) begin
      if ((chk == CHK_EXP_DIG) && is_digit) begin
        first <= 1'b0;
        if (first)       acc <= dval;
        else if (mul_op) acc <= acc * dval;
        else             acc <= acc + dval;
      end else if ((chk == CHK_AFT_DIG) && is_op) begin
        mul_op <= (sel_data == 8'h2A);
      end
    end
  end
`endif

endmodule
`default_nettype wire
